// File: rtl/lc4_dx_pkg.sv
// Shared LC4 definitions: opcodes, D/X stall codes and the X-stage control bundle.
// Imported by the decoder, the ALU and the D/X pipeline register.
package lc4_dx_pkg;

  typedef enum logic [3:0] {
    OP_BR      = 4'b0000,
    OP_ARITH   = 4'b0001,
    OP_CMP     = 4'b0010,
    OP_JSR     = 4'b0100,
    OP_LOGIC   = 4'b0101,
    OP_LDR     = 4'b0110,
    OP_STR     = 4'b0111,
    OP_RTI     = 4'b1000,
    OP_CONST   = 4'b1001,
    OP_SHIFT   = 4'b1010,
    OP_JMP     = 4'b1100,
    OP_HICONST = 4'b1101,
    OP_TRAP    = 4'b1111
  } lc4_opcode_e;

  localparam logic [1:0]  STALL_NONE     = 2'd0;
  localparam logic [1:0]  STALL_FLUSH    = 2'd2;
  localparam logic [1:0]  STALL_LOAD_USE = 2'd3;
  localparam logic [15:0] NOP_INSN       = 16'h0000;

  typedef struct packed {
    logic we;
    logic nzp_we;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_control;
    logic valid;
  } x_ctrl_t;

  function automatic lc4_opcode_e lc4_opcode(input logic [15:0] insn);
    return lc4_opcode_e'(insn[15:12]);
  endfunction

endpackage

// File: rtl/lc4_bypass_mux.sv
// Operand bypass for the X stage, zero latency: MX beats WX beats the registered value.
// Producers without both valid and we never forward; no backpressure.
module lc4_bypass_mux (
  input  logic [2:0]  rsel,
  input  logic [15:0] rdata,
  input  logic [2:0]  m_wsel,
  input  logic        m_we,
  input  logic        m_valid,
  input  logic [15:0] m_result,
  input  logic [2:0]  w_wsel,
  input  logic        w_we,
  input  logic        w_valid,
  input  logic [15:0] w_result,
  output logic [15:0] op_dat
);

  logic m_hit;
  logic w_hit;

  always_comb begin
    m_hit = m_valid & m_we & (m_wsel == rsel);
    w_hit = w_valid & w_we & (w_wsel == rsel);
    if (m_hit) begin
      op_dat = m_result;
    end else if (w_hit) begin
      op_dat = w_result;
    end else begin
      op_dat = rdata;
    end
  end

endmodule

// File: rtl/lc4_nbit_reg.sv
// N-bit pipeline register cell, one-cycle latency; writes only when gwe and we are both high.
// Asynchronous active-high reset to RST_VAL.
module lc4_nbit_reg #(
  parameter int            N       = 16,
  parameter logic [N-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (gwe && we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lc4_dx_stage.sv
// LC4 D->X pipeline register with MX/WX bypass, one-cycle latency, bypass adds none.
// Load-use raises o_stall (D holds, X gets a bubble); flush overrides it; gwe=0 freezes all state.
module lc4_dx_stage
  import lc4_dx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic [15:0] d_pc,
  input  logic [15:0] d_insn,
  input  logic [2:0]  d_r1sel,
  input  logic [2:0]  d_r2sel,
  input  logic [2:0]  d_wsel,
  input  logic        d_r1re,
  input  logic        d_r2re,
  input  logic        d_we,
  input  logic        d_nzp_we,
  input  logic        d_is_load,
  input  logic        d_is_store,
  input  logic        d_is_branch,
  input  logic        d_is_control,
  input  logic [15:0] d_r1data,
  input  logic [15:0] d_r2data,
  input  logic        d_valid,
  input  logic        flush,
  input  logic [2:0]  m_wsel,
  input  logic        m_we,
  input  logic        m_valid,
  input  logic [15:0] m_result,
  input  logic [2:0]  w_wsel,
  input  logic        w_we,
  input  logic        w_valid,
  input  logic [15:0] w_result,
  output logic        o_stall,
  output logic [15:0] x_pc,
  output logic [15:0] x_insn,
  output logic [15:0] x_r1data,
  output logic [15:0] x_r2data,
  output logic [2:0]  x_wsel,
  output logic [2:0]  x_r2sel,
  output logic        x_we,
  output logic        x_nzp_we,
  output logic        x_is_load,
  output logic        x_is_store,
  output logic        x_is_branch,
  output logic        x_is_control,
  output logic        x_valid,
  output logic [1:0]  x_stall_code
);

  logic [15:0] pc_d, pc_q;
  logic [15:0] insn_d, insn_q;
  logic [15:0] r1data_d, r1data_q;
  logic [15:0] r2data_d, r2data_q;
  logic [2:0]  r1sel_d, r1sel_q;
  logic [2:0]  r2sel_d, r2sel_q;
  logic [2:0]  wsel_d, wsel_q;
  x_ctrl_t     ctrl_d, ctrl_q;
  logic [1:0]  stall_code_d, stall_code_q;
  logic        load_use;

  // A store's data operand (r2) is consumed in M, where WM bypass covers it.
  always_comb begin
    load_use = ctrl_q.valid & ctrl_q.is_load & d_valid &
               ((d_r1re & (d_r1sel == wsel_q)) |
                (d_r2re & (d_r2sel == wsel_q) & ~d_is_store));
    o_stall  = load_use & ~flush;
  end

  // Bubbles still capture pc/selects/data so X never holds stale values.
  always_comb begin
    pc_d         = d_pc;
    r1sel_d      = d_r1sel;
    r2sel_d      = d_r2sel;
    wsel_d       = d_wsel;
    r1data_d     = d_r1data;
    r2data_d     = d_r2data;
    insn_d       = d_insn;
    ctrl_d       = '{we: d_we, nzp_we: d_nzp_we, is_load: d_is_load, is_store: d_is_store,
                     is_branch: d_is_branch, is_control: d_is_control, valid: d_valid};
    stall_code_d = STALL_NONE;
    if (flush) begin
      insn_d       = NOP_INSN;
      ctrl_d       = '0;
      stall_code_d = STALL_FLUSH;
    end else if (load_use) begin
      insn_d       = NOP_INSN;
      ctrl_d       = '0;
      stall_code_d = STALL_LOAD_USE;
    end
  end

  lc4_nbit_reg #(.N(16)) u_pc_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(pc_d), .q(pc_q)
  );

  lc4_nbit_reg #(.N(16)) u_insn_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(insn_d), .q(insn_q)
  );

  lc4_nbit_reg #(.N(16)) u_r1data_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(r1data_d), .q(r1data_q)
  );

  lc4_nbit_reg #(.N(16)) u_r2data_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(r2data_d), .q(r2data_q)
  );

  lc4_nbit_reg #(.N(3)) u_r1sel_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(r1sel_d), .q(r1sel_q)
  );

  lc4_nbit_reg #(.N(3)) u_r2sel_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(r2sel_d), .q(r2sel_q)
  );

  lc4_nbit_reg #(.N(3)) u_wsel_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(wsel_d), .q(wsel_q)
  );

  lc4_nbit_reg #(.N($bits(x_ctrl_t))) u_ctrl_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(ctrl_d), .q(ctrl_q)
  );

  // Reset leaves X looking like a flush bubble.
  lc4_nbit_reg #(.N(2), .RST_VAL(STALL_FLUSH)) u_stall_code_reg (
    .clk(clk), .rst(rst), .gwe(gwe), .we(1'b1), .d(stall_code_d), .q(stall_code_q)
  );

  lc4_bypass_mux u_byp_r1 (
    .rsel(r1sel_q), .rdata(r1data_q),
    .m_wsel(m_wsel), .m_we(m_we), .m_valid(m_valid), .m_result(m_result),
    .w_wsel(w_wsel), .w_we(w_we), .w_valid(w_valid), .w_result(w_result),
    .op_dat(x_r1data)
  );

  lc4_bypass_mux u_byp_r2 (
    .rsel(r2sel_q), .rdata(r2data_q),
    .m_wsel(m_wsel), .m_we(m_we), .m_valid(m_valid), .m_result(m_result),
    .w_wsel(w_wsel), .w_we(w_we), .w_valid(w_valid), .w_result(w_result),
    .op_dat(x_r2data)
  );

  always_comb begin
    x_pc         = pc_q;
    x_insn       = insn_q;
    x_wsel       = wsel_q;
    x_r2sel      = r2sel_q;
    x_we         = ctrl_q.we;
    x_nzp_we     = ctrl_q.nzp_we;
    x_is_load    = ctrl_q.is_load;
    x_is_store   = ctrl_q.is_store;
    x_is_branch  = ctrl_q.is_branch;
    x_is_control = ctrl_q.is_control;
    x_valid      = ctrl_q.valid;
    x_stall_code = stall_code_q;
  end

endmodule

// File: doc/lc4_dx_stage.md
LC4_DX_STAGE -- requirements
Module: lc4_dx_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port gwe, input, 1: global write enable; 0 freezes all state.
REQ-004 SHALL have ports d_pc, d_insn, input, 16 each: decoded instruction and its PC.
REQ-005 SHALL have ports d_r1sel, d_r2sel, d_wsel, input, 3 each, plus d_r1re, d_r2re, d_we, d_nzp_we, d_is_load, d_is_store, d_is_branch, d_is_control, input, 1 each: decode controls.
REQ-006 SHALL have ports d_r1data, d_r2data, input, 16 each: register-file reads, already WD-bypassed.
REQ-007 SHALL have port d_valid, input, 1: decode slot holds a real instruction.
REQ-008 SHALL have port flush, input, 1: mispredicted branch/jump resolved in X this cycle.
REQ-009 SHALL have ports m_wsel, input, 3, and m_we, m_valid, input, 1 each, plus m_result, input, 16: M-stage producer (MX bypass).
REQ-010 SHALL have ports w_wsel, input, 3, and w_we, w_valid, input, 1 each, plus w_result, input, 16: W-stage producer (WX bypass).
REQ-011 SHALL have port o_stall, output, 1: load-use hazard; fetch/decode must hold.
REQ-012 SHALL have ports x_pc, x_insn, x_r1data, x_r2data, output, 16 each: operands for the ALU (x_r1data, x_r2data bypassed).
REQ-013 SHALL have ports x_wsel, x_r2sel, output, 3 each, plus x_we, x_nzp_we, x_is_load, x_is_store, x_is_branch, x_is_control, x_valid, output, 1 each: registered controls.
REQ-014 SHALL have port x_stall_code, output, 2: 0 normal, 2 flush bubble, 3 load-use bubble.

Function
REQ-015 SHALL assert o_stall combinationally when x_valid & x_is_load & d_valid & ((d_r1re & d_r1sel==x_wsel) | (d_r2re & d_r2sel==x_wsel & !d_is_store)) and flush=0.
REQ-016 SHALL, on rising clk with gwe=1, load a bubble when flush=1 (code 2), else a bubble when o_stall=1 (code 3), else capture all d_* into x_* (code 0; x_valid=d_valid).
REQ-017 Bubble SHALL mean x_valid=0, x_insn=16'h0000, x_we=x_nzp_we=x_is_*=0, x_pc and data don't-care but held deterministic (captured from d_*).
REQ-018 flush SHALL take priority over o_stall on the same edge; o_stall SHALL be forced 0 while flush=1.
REQ-019 With gwe=0 SHALL hold every register; o_stall remains combinational.
REQ-020 x_r1data SHALL be m_result if m_valid & m_we & m_wsel==r1sel_q, else w_result if w_valid & w_we & w_wsel==r1sel_q, else registered r1data; same for x_r2data with r2sel_q.
REQ-021 MX SHALL have priority over WX when both match; bypass SHALL ignore producers with valid=0 or we=0.
REQ-022 Bypass SHALL apply regardless of r1re/r2re (harmless for unused operands); register R7 is bypassed like any other.
REQ-023 Latency SHALL be exactly one cycle from d_* to x_*; bypass adds zero cycles.

Reset
REQ-024 On rst=1 SHALL asynchronously clear: x_valid=0, x_insn=0, x_pc=0, x_r*data=0, all selects/controls 0, x_stall_code=2.
REQ-025 Reset mid-stall SHALL drop the held instruction; first post-reset edge with gwe=1 captures d_* normally.

Structure
REQ-026 Opcode constants and stall-code values (0/2/3) SHALL live in the shared LC4 definitions include used by decoder and ALU.
REQ-027 SHALL instantiate sub-module lc4_bypass_mux twice (one per operand); all registers SHALL use the codebase's nbit register cell with gwe/we.

Verification
REQ-028 LDR R1 in X, ADD R2,R1,R3 in D -> o_stall=1; next edge x_valid=0, x_stall_code=3, ADD captured one cycle later.
REQ-029 LDR R1 in X, STR R1,R2,#0 in D (R1 as r2) -> o_stall=0; STR as r1 base -> o_stall=1.
REQ-030 x r1sel=3, m_wsel=3 m_result=16'h1234, w_wsel=3 w_result=16'hBEEF -> x_r1data=16'h1234; drop m_we -> 16'hBEEF; drop both -> registered value.
REQ-031 flush=1 and load-use simultaneous -> x_stall_code=2, x_valid=0, o_stall=0.
REQ-032 gwe=0 for 3 cycles with changing d_* -> x_* unchanged; rst pulse mid-cycle -> all outputs cleared immediately, x_stall_code=2.
